// File: rtl/synapse_accumulator.sv
// synapse_accumulator
// Walks the synapse array one index per cycle and sums the weights of the
// synapses whose spike bit was set when the accumulation started. The sum
// and the number of contributing spikes are handed to the neuron update
// through a valid/ack handshake.
//
// Handshake:
//   - start_i is taken only on an edge where ready_o=1. Any start_i seen
//     outside IDLE is dropped, not queued.
//   - valid_o=1 means sum_o/count_o hold a finished result. They stay frozen
//     until ack_i is sampled high while valid_o=1.
//   - ack_i is taken only on an edge where valid_o=1. If start_i is high on
//     that same edge it is ignored, because ready_o is still 0 there.
//   - ready_o/valid_o are registers, so there is no combinational path from
//     any input to any output.

module synapse_accumulator #(
  parameter int NUM_SYNAPSES = 100,
  parameter int WIDTH_P      = 8,
  parameter int ACC_WIDTH    = WIDTH_P + $clog2(NUM_SYNAPSES),
  parameter int CNT_WIDTH    = $clog2(NUM_SYNAPSES + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [WIDTH_P-1:0]   weights_i [0:NUM_SYNAPSES-1],
  input  logic [NUM_SYNAPSES-1:0] spikes_i,
  input  logic                 start_i,
  input  logic                 ack_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic [1:0]           state_o
);

  // Guard the index width for the degenerate single-synapse case.
  localparam int IDX_W = (NUM_SYNAPSES > 1) ? $clog2(NUM_SYNAPSES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYNAPSES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_SYNAPSES-1:0] spike_q;
  logic [ACC_WIDTH-1:0]    sum_q;
  logic [CNT_WIDTH-1:0]    count_q;
  logic                    ready_q;
  logic                    valid_q;
  logic                    last_idx;

  assign last_idx = (idx_q == LAST_IDX);

  // State register plus handshake flags, which track the next state so they
  // are registered outputs rather than decodes of the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      valid_q <= (state_d == DONE);
    end
  end

  // Next-state logic: start only from IDLE, finish after the last index,
  // leave DONE only on ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = ACCUM;
      ACCUM:   if (last_idx) state_d = DONE;
      DONE:    if (ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch spikes and clear on start, then add one live weight per
  // cycle for every latched spike; results hold outside ACCUM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= '0;
      spike_q <= '0;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            spike_q <= spikes_i;
            sum_q   <= '0;
            count_q <= '0;
            idx_q   <= '0;
          end
        end
        ACCUM: begin
          if (spike_q[idx_q]) begin
            sum_q   <= sum_q + ACC_WIDTH'(weights_i[idx_q]);
            count_q <= count_q + CNT_WIDTH'(1);
          end
          // The index parks on the last synapse instead of wrapping.
          if (!last_idx) begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign count_o = count_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_synapse_accumulator.sv
// Directed bench for synapse_accumulator with the default 100 x 8-bit shape.

module tb_synapse_accumulator;

  localparam int N   = 100;
  localparam int W   = 8;
  localparam int ACC = 15;
  localparam int CNT = 7;

  // ---------------- clock / reset ----------------
  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic [W-1:0]   weights [0:N-1];
  logic [N-1:0]   spikes_i;
  logic           start_i;
  logic           ack_i;
  logic           ready_o;
  logic           valid_o;
  logic [ACC-1:0] sum_o;
  logic [CNT-1:0] count_o;
  logic [1:0]     state_o;

  always #5 clk_i = ~clk_i;

  synapse_accumulator #(
    .NUM_SYNAPSES(N),
    .WIDTH_P(W)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .weights_i(weights),
    .spikes_i (spikes_i),
    .start_i  (start_i),
    .ack_i    (ack_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .sum_o    (sum_o),
    .count_o  (count_o),
    .state_o  (state_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [ACC-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_weights_const(input logic [W-1:0] v);
    for (int i = 0; i < N; i++) weights[i] = v;
  endtask

  // One-cycle start pulse; returns #1 after the accepting edge E0.
  task automatic do_start(input logic [N-1:0] spk, input logic [ACC-1:0] exp_sum);
    spikes_i = spk;
    start_i  = 1'b1;
    exp_q.push_back(exp_sum);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  // Counts edges until valid_o rises, bounded.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!valid_o && cyc < 300) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [CNT-1:0] exp_cnt);
    logic [ACC-1:0] exp_sum;
    exp_sum = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check_eq({tag, "_valid"}, valid_o, 1);
    check_eq({tag, "_sum"}, sum_o, exp_sum);
    check_eq({tag, "_count"}, count_o, exp_cnt);
  endtask

  task automatic do_ack(input string tag);
    logic [ACC-1:0] s;
    logic [CNT-1:0] c;
    s = sum_o;
    c = count_o;
    ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    ack_i = 1'b0;
    check_eq({tag, "_ack_valid"}, valid_o, 0);
    check_eq({tag, "_ack_ready"}, ready_o, 1);
    check_eq({tag, "_ack_sum_held"}, sum_o, s);
    check_eq({tag, "_ack_cnt_held"}, count_o, c);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    logic [N-1:0] even_mask;

    rst_ni   = 1'b0;
    start_i  = 1'b0;
    ack_i    = 1'b0;
    spikes_i = '0;
    set_weights_const(8'd0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    #1;
    check_eq("rst_ready", ready_o, 1);
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_sum", sum_o, 0);
    check_eq("rst_count", count_o, 0);
    check_eq("rst_state", state_o, 0);

    // ack outside DONE is ignored
    ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    ack_i = 1'b0;
    check_eq("stray_ack_ready", ready_o, 1);

    // T1: all spikes, all weights 255 -> 25500 / 100, latency 100
    set_weights_const(8'd255);
    do_start('1, 15'd25500);
    check_eq("t1_ready_fall", ready_o, 0);
    check_eq("t1_state_accum", state_o, 1);
    wait_valid(cyc);
    check_eq("t1_latency", cyc, 100);
    check_result("t1", 7'd100);
    check_eq("t1_state_done", state_o, 2);
    do_ack("t1");

    // T2: no spikes, arbitrary weights -> 0 / 0
    for (int i = 0; i < N; i++) weights[i] = 8'(i * 37 + 11);
    do_start('0, 15'd0);
    wait_valid(cyc);
    check_eq("t2_latency", cyc, 100);
    check_result("t2", 7'd0);
    do_ack("t2");

    // T3: even spikes, weight[i]=i, spikes flipped to all-ones after start
    for (int i = 0; i < N; i++) begin
      weights[i]   = 8'(i);
      even_mask[i] = (i % 2 == 0);
    end
    do_start(even_mask, 15'd2450);
    @(posedge clk_i);
    #1;
    spikes_i = '1;
    wait_valid(cyc);
    check_eq("t3_latency", cyc + 1, 100);
    check_result("t3", 7'd50);
    do_ack("t3");

    // T4: weights 1, switched to 3 once idx 0..49 are done -> 50 + 150
    set_weights_const(8'd1);
    do_start('1, 15'd200);
    repeat (50) @(posedge clk_i);
    #1;
    set_weights_const(8'd3);
    wait_valid(cyc);
    check_eq("t4_latency", cyc + 50, 100);
    check_result("t4", 7'd100);

    // T5: hold DONE for 10 cycles with start pulses; nothing may move
    for (int i = 0; i < 10; i++) begin
      start_i = (i % 2 == 0);
      @(posedge clk_i);
      #1;
      check_eq("t5_hold_valid", valid_o, 1);
      check_eq("t5_hold_ready", ready_o, 0);
      check_eq("t5_hold_sum", sum_o, 200);
      check_eq("t5_hold_count", count_o, 100);
    end
    start_i = 1'b0;
    // ack and start together: ack wins, start dropped
    ack_i   = 1'b1;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    ack_i   = 1'b0;
    start_i = 1'b0;
    check_eq("t5_both_valid", valid_o, 0);
    check_eq("t5_both_ready", ready_o, 1);
    check_eq("t5_both_sum", sum_o, 200);
    @(posedge clk_i);
    #1;
    check_eq("t5_no_restart", state_o, 0);
    check_eq("t5_sum_kept", sum_o, 200);

    // T6: reset in the middle of an accumulation (idx = 40)
    set_weights_const(8'd255);
    do_start('1, 15'd0);
    void'(exp_q.pop_back());
    repeat (40) @(posedge clk_i);
    #1;
    check_eq("t6_mid_sum", sum_o, 40 * 255);
    rst_ni = 1'b0;
    #1;
    check_eq("t6_rst_ready", ready_o, 1);
    check_eq("t6_rst_valid", valid_o, 0);
    check_eq("t6_rst_sum", sum_o, 0);
    check_eq("t6_rst_count", count_o, 0);
    check_eq("t6_rst_state", state_o, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    set_weights_const(8'd5);
    do_start('1, 15'd500);
    wait_valid(cyc);
    check_eq("t6_latency", cyc, 100);
    check_result("t6", 7'd100);
    do_ack("t6");

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
